// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared loader states and instruction-memory geometry
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    LOAD,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int IMEM_DEPTH_BYTES = 1024;
  localparam int INSTR_BYTES      = 4;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction RAM writer
// Optional trailing XOR checksum byte: IMEM_LOADER_CSUM_EN
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_rst_hold,
  output logic        done,
  output logic        err
);

  localparam int SUM_W = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(1) << ADDR_WIDTH;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t PAYLOAD_END = CSUM;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t state, state_nx;

  logic [7:0]            len_hi;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [15:0]           len_word;
  logic [SUM_W-1:0]      frame_end;
  logic                  xfer;
  logic                  launch;

  assign len_word  = {len_hi, in_data};
  // Widened sum so a frame running past the top of memory cannot wrap.
  assign frame_end = SUM_W'(BASE_ADDR) + SUM_W'(len_word);
  assign xfer      = in_valid && in_ready;
  assign launch    = start && (state == IDLE || state == DONE || state == ERR);

  assign in_ready     = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == LOAD)   || (state == CSUM);
  assign done         = (state == DONE);
  assign err          = (state == ERR);
  assign cpu_rst_hold = (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = LEN_HI;
      LEN_HI:          if (xfer) state_nx = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_word == 16'd0)      state_nx = PAYLOAD_END;
          else if (frame_end > LIMIT) state_nx = ERR;
          else                        state_nx = LOAD;
        end
      end
      LOAD:            if (xfer && remaining == 16'd1) state_nx = PAYLOAD_END;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:            if (xfer) state_nx = (in_data == csum) ? DONE : ERR;
`endif
      default:         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi    <= 8'd0;
      remaining <= 16'd0;
      wr_ptr    <= ADDR_WIDTH'(BASE_ADDR);
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (launch) wr_ptr <= ADDR_WIDTH'(BASE_ADDR);
      if (state == LEN_HI && xfer) len_hi <= in_data;
      if (state == LEN_LO && xfer) remaining <= len_word;
      if (state == LOAD && xfer) begin
        mem_we    <= 1'b1;
        mem_addr  <= 32'(wr_ptr);
        mem_wdata <= in_data;
        wr_ptr    <= wr_ptr + 1'b1;
        remaining <= remaining - 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        csum <= 8'd0;
    else if (launch)                csum <= 8'd0;
    else if (state == LOAD && xfer) csum <= csum ^ in_data;
  end
`endif

endmodule
